// File: rtl/control_unit_if.sv
// Control bundle between the multi-cycle main control FSM and the datapath.
// The FSM drives every enable and select; the datapath supplies the IR opcode field.
interface control_unit_if;
   logic [6:0] instruction_opcode_i;
   logic       pc_write_o;
   logic       pc_write_cond_o;
   logic       pc_source_o;
   logic       ir_write_o;
   logic       memory_read_o;
   logic       memory_write_o;
   logic       lorD_o;
   logic       reg_write_o;
   logic       memory_to_reg_o;
   logic [1:0] aluop_o;
   logic       is_immediate_o;
   logic [1:0] alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic       illegal_o;
   logic [3:0] state_o;

   modport master (
      input  instruction_opcode_i,
      output pc_write_o, pc_write_cond_o, pc_source_o, ir_write_o, memory_read_o,
             memory_write_o, lorD_o, reg_write_o, memory_to_reg_o, aluop_o,
             is_immediate_o, alu_src_a_o, alu_src_b_o, illegal_o, state_o
   );

   modport slave (
      output instruction_opcode_i,
      input  pc_write_o, pc_write_cond_o, pc_source_o, ir_write_o, memory_read_o,
             memory_write_o, lorD_o, reg_write_o, memory_to_reg_o, aluop_o,
             is_immediate_o, alu_src_a_o, alu_src_b_o, illegal_o, state_o
   );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle RV32I main control FSM: fetch, decode, execute, memory, write-back.
// Outputs are decoded from the state register; strobes are gated off while in reset.
module control_unit (
   input  logic           clk,
   input  logic           rst_n,
   control_unit_if.master ctrl_io
);
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIType  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StJal      = 4'd10,
      StJalr     = 4'd11,
      StLui      = 4'd12,
      StAuipc    = 4'd13
   } state_e;

   state_e     state_q, state_d;
   logic       pc_write, pc_write_cond, ir_write, memory_read, memory_write;
   logic       reg_write, illegal;
   logic       pc_source, lord, memory_to_reg, is_immediate;
   logic [1:0] aluop, src_a, src_b;
   logic [6:0] opcode;

   assign opcode = ctrl_io.instruction_opcode_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = StFetch;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      memory_read   = 1'b0;
      memory_write  = 1'b0;
      reg_write     = 1'b0;
      illegal       = 1'b0;
      pc_source     = 1'b0;
      lord          = 1'b0;
      memory_to_reg = 1'b0;
      is_immediate  = 1'b1;
      aluop         = 2'b00;
      src_a         = 2'b00;
      src_b         = 2'b00;
      case (state_q)
         StFetch: begin
            memory_read = 1'b1;
            ir_write    = 1'b1;
            pc_write    = 1'b1;
            src_b       = 2'b01;
            state_d     = StDecode;
         end
         StDecode: begin
            // Speculatively compute the branch/JAL target into ALUOut.
            src_a = 2'b10;
            src_b = 2'b10;
            case (opcode)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRType:         state_d = StExecR;
               OpIType:         state_d = StExecI;
               OpBranch:        state_d = StBranch;
               OpJal:           state_d = StJal;
               OpJalr:          state_d = StJalr;
               OpLui:           state_d = StLui;
               OpAuipc:         state_d = StAuipc;
               default: begin
                  illegal = 1'b1;
                  state_d = StFetch;
               end
            endcase
         end
         StMemAdr: begin
            src_a   = 2'b01;
            src_b   = 2'b10;
            state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            memory_read = 1'b1;
            lord        = 1'b1;
            state_d     = StMemWb;
         end
         StMemWb: begin
            reg_write     = 1'b1;
            memory_to_reg = 1'b1;
         end
         StMemWrite: begin
            memory_write = 1'b1;
            lord         = 1'b1;
         end
         StExecR: begin
            src_a   = 2'b01;
            aluop   = 2'b10;
            state_d = StAluWb;
         end
         StExecI: begin
            src_a        = 2'b01;
            src_b        = 2'b10;
            aluop        = 2'b10;
            is_immediate = 1'b0;
            state_d      = StAluWb;
         end
         StAluWb: reg_write = 1'b1;
         StBranch: begin
            src_a         = 2'b01;
            aluop         = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 1'b1;
         end
         StJal: begin
            // PC takes the target from ALUOut while ALUOut captures the link address.
            pc_write  = 1'b1;
            pc_source = 1'b1;
            src_a     = 2'b10;
            src_b     = 2'b01;
            state_d   = StAluWb;
         end
         StJalr: begin
            src_a   = 2'b01;
            src_b   = 2'b10;
            state_d = StJal;
         end
         StLui: begin
            src_a   = 2'b11;
            src_b   = 2'b10;
            state_d = StAluWb;
         end
         StAuipc: begin
            src_a   = 2'b10;
            src_b   = 2'b10;
            state_d = StAluWb;
         end
         default: begin
            src_b = 2'b01;
         end
      endcase
   end

   assign ctrl_io.pc_write_o      = pc_write & rst_n;
   assign ctrl_io.pc_write_cond_o = pc_write_cond & rst_n;
   assign ctrl_io.ir_write_o      = ir_write & rst_n;
   assign ctrl_io.memory_read_o   = memory_read & rst_n;
   assign ctrl_io.memory_write_o  = memory_write & rst_n;
   assign ctrl_io.reg_write_o     = reg_write & rst_n;
   assign ctrl_io.illegal_o       = illegal & rst_n;
   assign ctrl_io.pc_source_o     = pc_source;
   assign ctrl_io.lorD_o          = lord;
   assign ctrl_io.memory_to_reg_o = memory_to_reg;
   assign ctrl_io.is_immediate_o  = is_immediate;
   assign ctrl_io.aluop_o         = aluop;
   assign ctrl_io.alu_src_a_o     = src_a;
   assign ctrl_io.alu_src_b_o     = src_b;
   assign ctrl_io.state_o         = state_q;
endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: an instruction-level model predicts the state walk
// and per-state outputs; a literal trace pins the opening directed program.
module tb_control_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   control_unit_if bus ();

   control_unit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctrl_io (bus)
   );

   typedef struct packed {
      logic       pcw, pcwc, pcs, irw, mr, mw, lord, rw, m2r;
      logic [1:0] aluop;
      logic       imm;
      logic [1:0] sa, sb;
      logic       ill;
   } outs_t;

   int         checks = 0;
   int         failures = 0;
   int         exp_state = 0;
   int         seq_q[$];
   logic [6:0] cur_op;
   logic [6:0] forced_q[$];
   logic [6:0] legal_ops[9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
   bit         directed = 1'b1;
   int         rst_hold = 3;
   int         log_st[$];
   bit         log_ill[$];
   int         exp_log[28] = '{0, 0, 0, 1, 6, 8, 0, 1, 2, 3, 4, 0, 1, 7, 8, 0, 1, 9,
                               0, 1, 11, 10, 8, 0, 1, 0, 1, 2};

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level view: the full list of states an opcode walks through.
   task automatic start_instr();
      if (forced_q.size() > 0) cur_op = forced_q.pop_front();
      else if ($urandom_range(3) == 0) cur_op = 7'($urandom);
      else cur_op = legal_ops[$urandom_range(8)];
      seq_q.delete();
      case (cur_op)
         7'h03:   seq_q = '{1, 2, 3, 4};
         7'h23:   seq_q = '{1, 2, 5};
         7'h33:   seq_q = '{1, 6, 8};
         7'h13:   seq_q = '{1, 7, 8};
         7'h63:   seq_q = '{1, 9};
         7'h6f:   seq_q = '{1, 10, 8};
         7'h67:   seq_q = '{1, 11, 10, 8};
         7'h37:   seq_q = '{1, 12, 8};
         7'h17:   seq_q = '{1, 13, 8};
         default: seq_q = '{1};
      endcase
   endtask

   function automatic outs_t exp_out(input int st, input logic [6:0] op, input logic rst_ok);
      outs_t o = '0;
      bit legal = 1'b0;
      foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
      o.imm = 1'b1;
      case (st)
         0:  begin o.mr = 1; o.irw = 1; o.pcw = 1; o.sb = 2'b01; end
         1:  begin o.sa = 2'b10; o.sb = 2'b10; o.ill = !legal; end
         2:  begin o.sa = 2'b01; o.sb = 2'b10; end
         3:  begin o.mr = 1; o.lord = 1; end
         4:  begin o.rw = 1; o.m2r = 1; end
         5:  begin o.mw = 1; o.lord = 1; end
         6:  begin o.sa = 2'b01; o.aluop = 2'b10; end
         7:  begin o.sa = 2'b01; o.sb = 2'b10; o.aluop = 2'b10; o.imm = 0; end
         8:  o.rw = 1;
         9:  begin o.sa = 2'b01; o.aluop = 2'b01; o.pcwc = 1; o.pcs = 1; end
         10: begin o.pcw = 1; o.pcs = 1; o.sa = 2'b10; o.sb = 2'b01; end
         11: begin o.sa = 2'b01; o.sb = 2'b10; end
         12: begin o.sa = 2'b11; o.sb = 2'b10; end
         13: begin o.sa = 2'b10; o.sb = 2'b10; end
         default: ;
      endcase
      if (!rst_ok) begin
         o.pcw = 0; o.pcwc = 0; o.irw = 0; o.mr = 0; o.mw = 0; o.rw = 0; o.ill = 0;
      end
      return o;
   endfunction

   // Per-cycle compare against the model, sampled on the falling edge.
   always @(negedge clk) begin
      outs_t e;
      e = exp_out(exp_state, cur_op, rst_n);
      chk("state", {4'h0, bus.state_o}, 8'(exp_state));
      chk("pc_write", {7'h0, bus.pc_write_o}, {7'h0, e.pcw});
      chk("pc_write_cond", {7'h0, bus.pc_write_cond_o}, {7'h0, e.pcwc});
      chk("pc_source", {7'h0, bus.pc_source_o}, {7'h0, e.pcs});
      chk("ir_write", {7'h0, bus.ir_write_o}, {7'h0, e.irw});
      chk("memory_read", {7'h0, bus.memory_read_o}, {7'h0, e.mr});
      chk("memory_write", {7'h0, bus.memory_write_o}, {7'h0, e.mw});
      chk("lorD", {7'h0, bus.lorD_o}, {7'h0, e.lord});
      chk("reg_write", {7'h0, bus.reg_write_o}, {7'h0, e.rw});
      chk("memory_to_reg", {7'h0, bus.memory_to_reg_o}, {7'h0, e.m2r});
      chk("aluop", {6'h0, bus.aluop_o}, {6'h0, e.aluop});
      chk("is_immediate", {7'h0, bus.is_immediate_o}, {7'h0, e.imm});
      chk("alu_src_a", {6'h0, bus.alu_src_a_o}, {6'h0, e.sa});
      chk("alu_src_b", {6'h0, bus.alu_src_b_o}, {6'h0, e.sb});
      chk("illegal", {7'h0, bus.illegal_o}, {7'h0, e.ill});
      if (log_st.size() < 28) begin
         log_st.push_back(int'(bus.state_o));
         log_ill.push_back(bus.illegal_o);
      end
   end

   initial begin
      bit do_rst;
      forced_q = '{7'h33, 7'h03, 7'h13, 7'h63, 7'h67, 7'h7f, 7'h23};
      start_instr();
      bus.instruction_opcode_i = cur_op;
      repeat (3000) begin
         @(posedge clk);
         if (rst_n) begin
            if (seq_q.size() == 0) begin
               exp_state = 0;
               start_instr();
            end else begin
               exp_state = seq_q.pop_front();
            end
         end
         do_rst = 1'b0;
         if (rst_n) begin
            if (directed) do_rst = (exp_state == 5);
            else do_rst = ($urandom_range(63) == 0);
         end
         if (do_rst) begin
            #2;
            if (directed) begin
               chk("sw_state_before_rst", {4'h0, bus.state_o}, 8'd5);
               chk("sw_memwrite_before_rst", {7'h0, bus.memory_write_o}, 8'd1);
            end
            rst_n = 1'b0;
            #1;
            chk("rst_memwrite", {7'h0, bus.memory_write_o}, 8'd0);
            chk("rst_state", {4'h0, bus.state_o}, 8'd0);
            chk("rst_strobes", {1'b0, bus.pc_write_o, bus.pc_write_cond_o, bus.ir_write_o,
                                bus.memory_read_o, bus.memory_write_o, bus.reg_write_o,
                                bus.illegal_o}, 8'd0);
            exp_state = 0;
            start_instr();
            rst_hold = $urandom_range(3, 1);
            directed = 1'b0;
         end
         @(negedge clk);
         #1;
         if (!rst_n) begin
            if (rst_hold > 0) rst_hold--;
            if (rst_hold == 0) rst_n = 1'b1;
         end
         // Opcode only matters in DECODE and MEMADR; scramble it everywhere else.
         if (exp_state == 0) bus.instruction_opcode_i = cur_op;
         else if (exp_state != 1 && exp_state != 2) bus.instruction_opcode_i = 7'($urandom);
      end
      chk("trace_len", 8'(log_st.size()), 8'd28);
      for (int i = 0; i < 28 && i < log_st.size(); i++) begin
         chk($sformatf("trace_state[%0d]", i), 8'(log_st[i]), 8'(exp_log[i]));
         chk($sformatf("trace_illegal[%0d]", i), {7'h0, log_ill[i]}, (i == 24) ? 8'd1 : 8'd0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle RISC-V (RV32I subset) main control FSM: sequences fetch, decode, execute, memory and write-back, and drives every datapath enable plus the `aluop_o` and `is_immediate_o` fields consumed by the ALU control decoder. It sits between the instruction register's opcode field and the multi-cycle datapath (PC, IR, register file, ALUOut, unified memory). Outputs are Moore: decoded from the state register only.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `instruction_opcode_i`  in  7  IR[6:0]; stable from end of FETCH until next FETCH
- `pc_write_o`  out  1  unconditional PC load
- `pc_write_cond_o`  out  1  PC load qualified by ALU branch result (datapath ANDs)
- `pc_source_o`  out  1  0: ALU result, 1: ALUOut register
- `ir_write_o`  out  1  IR load
- `memory_read_o`  out  1  memory read strobe
- `memory_write_o`  out  1  memory write strobe
- `lorD_o`  out  1  memory address: 0 PC, 1 ALUOut
- `reg_write_o`  out  1  register-file write
- `memory_to_reg_o`  out  1  write-back source: 0 ALUOut, 1 MDR
- `aluop_o`  out  2  to ALU control: 00 add (load/store), 01 branch compare, 10 funct-decoded
- `is_immediate_o`  out  1  to ALU control: 0 in EXEC_I, 1 otherwise (low marks I-type so ADDI never decodes as SUB)
- `alu_src_a_o`  out  2  00 PC, 01 rs1 (A reg), 10 old PC, 11 zero
- `alu_src_b_o`  out  2  00 rs2 (B reg), 01 constant 4, 10 immediate, 11 unused
- `illegal_o`  out  1  one-cycle pulse in DECODE on unrecognised opcode
- `state_o`  out  4  current state encoding (debug/verification)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, AUIPC 13; 14/15 unreachable, decoded as FETCH next.
- Every output is 0 (or 1 for `is_immediate_o`) unless listed for the state.
- FETCH: memory_read, ir_write, pc_write=1; src_a 00, src_b 01, aluop 00, pc_source 0. -> DECODE.
- DECODE: src_a 10, src_b 10, aluop 00 (branch/JAL target into ALUOut). Next by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC; else illegal_o=1, -> FETCH.
- MEMADR: src_a 01, src_b 10, aluop 00. -> MEMREAD if opcode 0000011, else MEMWRITE.
- MEMREAD: memory_read=1, lorD=1. -> MEMWB. MEMWB: reg_write=1, memory_to_reg=1. -> FETCH.
- MEMWRITE: memory_write=1, lorD=1. -> FETCH.
- EXEC_R: src_a 01, src_b 00, aluop 10, is_immediate 1. EXEC_I: src_a 01, src_b 10, aluop 10, is_immediate 0. Both -> ALUWB.
- ALUWB: reg_write=1, memory_to_reg 0. -> FETCH.
- BRANCH: src_a 01, src_b 00, aluop 01, pc_write_cond=1, pc_source 1. -> FETCH.
- JAL: pc_write=1, pc_source 1 (PC <- target in ALUOut); src_a 10, src_b 01, aluop 00 (old PC+4 into ALUOut at same edge). -> ALUWB.
- JALR: src_a 01, src_b 10, aluop 00 (rs1+imm into ALUOut). -> JAL. Bit-0 clearing is the datapath's job.
- LUI: src_a 11, src_b 10, aluop 00. AUIPC: src_a 10, src_b 10, aluop 00. Both -> ALUWB.

## Timing
- rst_n low: state forced to FETCH asynchronously; while low, all strobes (pc_write, pc_write_cond, ir_write, memory_read, memory_write, reg_write, illegal) forced 0, other outputs show FETCH values, state_o=0.
- First rising edge after rst_n release executes FETCH. Reset asserted mid-instruction aborts it immediately; no write strobe is asserted after the asserting edge.
- Cycles per instruction: load 5, store 4, R/I 4, branch 3, JAL 4, JALR 5, LUI/AUIPC 4, illegal 2.
- Opcode sampled only in DECODE and MEMADR; changes at other times have no effect.

## Test plan
- Reset: hold rst_n=0 with opcode 0110011, toggle clk -> state_o=0, all strobes 0; release -> FETCH, then DECODE, next edge EXEC_R.
- LW (0000011): state_o 0,1,2,3,4,0; memory_read=1 in states 0 and 3, lorD=1 only in 3, reg_write & memory_to_reg=1 only in 4.
- R vs I: 0110011 -> EXEC_R with aluop=10, is_immediate=1, src_b=00; 0010011 -> EXEC_I with is_immediate=0, src_b=10; both then ALUWB with reg_write=1.
- BEQ (1100011): 0,1,9,0; in 9 aluop=01, pc_write_cond=1, pc_write=0.
- JALR (1100111): 0,1,11,10,8,0; pc_write=1 only in 0 and 10; reg_write only in 8.
- Illegal 1111111: 0,1,0 with illegal_o=1 only in DECODE; rst_n pulsed low during MEMWRITE -> memory_write drops at once, state_o=0.
